// File: rtl/or3_response_checker.sv
// ---------------------------------------------------------------------------
// or3_response_checker
// Exhaustive 8-vector response checker for a 3-input OR (or NOR when INVERT=1)
// gate under test. After START it walks {A1,A2,A3} through 000..111. Each
// vector is preceded by GAP_CYCLES idle cycles and held for SETTLE_CYCLES
// cycles. ZN is sampled on the last settle cycle of each vector.
// Optional feature macro: OR3_CHK_RESULT_MAP_EN (per-vector mismatch bitmap).
// ---------------------------------------------------------------------------
module or3_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned GAP_CYCLES    = 5,
  parameter bit          INVERT        = 1'b0
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FAIL_VEC,
  output logic [7:0] RESULT_MAP
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [7:0] GAP_LAST    = (GAP_CYCLES == 32'd0) ? 8'd0 : 8'(GAP_CYCLES - 32'd1);
  localparam bit         HAS_GAP     = (GAP_CYCLES != 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [2:0]  a_q,     a_d;
  logic [3:0]  err_q,   err_d;
  logic [2:0]  fail_q,  fail_d;
  logic        pass_q,  pass_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        exp_s;
  logic        hit_s;
  logic        clr_s;

  // Expected gate response for the vector currently applied (index == stimulus).
  function automatic logic expected_zn(input logic [2:0] vec, input logic inv);
    return (|vec) ^ inv;
  endfunction

  // Next-state, stimulus and result bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = a_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    hit_s   = 1'b0;
    clr_s   = 1'b0;
    exp_s   = expected_zn(idx_q, INVERT);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          clr_s  = 1'b1;
          err_d  = 4'd0;
          fail_d = 3'd0;
          pass_d = 1'b0;
          idx_d  = 3'd0;
          cnt_d  = 8'd0;
          if (HAS_GAP) begin
            state_d = ST_GAP;
          end else begin
            // No gap: first vector is applied on the same edge.
            state_d = ST_SETTLE;
            a_d     = 3'd0;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd0;
          a_d     = idx_q;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = 8'd0;
          if (ZN != exp_s) begin
            hit_s = 1'b1;
            err_d = (err_q == 4'd8) ? 4'd8 : (err_q + 4'd1);
            if (err_q == 4'd0) begin
              fail_d = idx_q;
            end else begin
              fail_d = fail_q;
            end
          end else begin
            hit_s = 1'b0;
          end
          if (idx_q == 3'd7) begin
            // Sweep finished: park stimulus at zero and publish verdict.
            state_d = ST_DONE;
            a_d     = 3'd0;
            pass_d  = (err_d == 4'd0);
          end else begin
            idx_d = idx_q + 3'd1;
            if (HAS_GAP) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_SETTLE;
              a_d     = idx_q + 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        a_d     = 3'd0;
      end
    endcase

    busy_d = (state_d == ST_GAP) || (state_d == ST_SETTLE);
    done_d = (state_d == ST_DONE);
  end

  // State, stimulus and result registers; reset aborts any sweep in progress.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      a_q     <= 3'd0;
      err_q   <= 4'd0;
      fail_q  <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef OR3_CHK_RESULT_MAP_EN
  logic [7:0] map_q, map_d;

  // Per-vector mismatch bitmap: cleared on an accepted START, set on a miss.
  always_comb begin
    map_d = map_q;
    if (clr_s) begin
      map_d = 8'h00;
    end else if (hit_s) begin
      map_d[idx_q] = 1'b1;
    end else begin
      map_d = map_q;
    end
  end

  // Bitmap register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      map_q <= 8'h00;
    end else begin
      map_q <= map_d;
    end
  end

  assign RESULT_MAP = map_q;
`else
  logic unused_map_s;
  assign unused_map_s = clr_s ^ hit_s;
  assign RESULT_MAP   = 8'h00;
`endif

  assign {A1, A2, A3} = a_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign PASS         = pass_q;
  assign ERR_CNT      = err_q;
  assign FAIL_VEC     = fail_q;

endmodule

// File: tb/tb_or3_response_checker.sv
// ---------------------------------------------------------------------------
// tb_or3_response_checker
// Two checker instances: default parameters (gap 5, settle 10, OR3) and a
// fast NOR3 build (gap 0, settle 1, INVERT=1). A behavioural gate model with
// selectable faults drives ZN; expectations come from a table and from a
// vector-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_or3_response_checker;

  logic ck = 1'b0;
  logic rn = 1'b0;
  always #5 ck = ~ck;

  // Gate model modes: 0 ideal OR3, 1 ideal NOR3, 2 stuck-at-0, 3 OR3 with flip mask
  int         mode0 = 0, mode1 = 0;
  logic [7:0] mask0 = 8'h00, mask1 = 8'h00;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       zn0, zn1;

  logic       d0_a1, d0_a2, d0_a3, d0_busy, d0_done, d0_pass;
  logic [3:0] d0_err;
  logic [2:0] d0_fail;
  logic [7:0] d0_map;
  logic       d1_a1, d1_a2, d1_a3, d1_busy, d1_done, d1_pass;
  logic [3:0] d1_err;
  logic [2:0] d1_fail;
  logic [7:0] d1_map;

  function automatic logic gate_out(input int mode, input logic [7:0] mask, input logic [2:0] v);
    case (mode)
      0:       return (v != 3'd0);
      1:       return (v == 3'd0);
      2:       return 1'b0;
      default: return (v != 3'd0) ^ mask[v];
    endcase
  endfunction

  assign zn0 = gate_out(mode0, mask0, {d0_a1, d0_a2, d0_a3});
  assign zn1 = gate_out(mode1, mask1, {d1_a1, d1_a2, d1_a3});

  or3_response_checker u_def (
    .CK(ck), .RN(rn), .START(start0), .ZN(zn0),
    .A1(d0_a1), .A2(d0_a2), .A3(d0_a3),
    .BUSY(d0_busy), .DONE(d0_done), .PASS(d0_pass),
    .ERR_CNT(d0_err), .FAIL_VEC(d0_fail), .RESULT_MAP(d0_map)
  );

  or3_response_checker #(.SETTLE_CYCLES(1), .GAP_CYCLES(0), .INVERT(1'b1)) u_fast (
    .CK(ck), .RN(rn), .START(start1), .ZN(zn1),
    .A1(d1_a1), .A2(d1_a2), .A3(d1_a3),
    .BUSY(d1_busy), .DONE(d1_done), .PASS(d1_pass),
    .ERR_CNT(d1_err), .FAIL_VEC(d1_fail), .RESULT_MAP(d1_map)
  );

  // Selected-instance view
  logic       sel = 1'b0;
  logic [2:0] cur_a;
  logic       cur_busy, cur_done, cur_pass;
  logic [3:0] cur_err;
  logic [2:0] cur_fail;
  logic [7:0] cur_map;
  assign cur_a    = sel ? {d1_a1, d1_a2, d1_a3} : {d0_a1, d0_a2, d0_a3};
  assign cur_busy = sel ? d1_busy : d0_busy;
  assign cur_done = sel ? d1_done : d0_done;
  assign cur_pass = sel ? d1_pass : d0_pass;
  assign cur_err  = sel ? d1_err  : d0_err;
  assign cur_fail = sel ? d1_fail : d0_fail;
  assign cur_map  = sel ? d1_map  : d0_map;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask

  function automatic logic [7:0] map_visible(input logic [7:0] m);
`ifdef OR3_CHK_RESULT_MAP_EN
    return m;
`else
    return 8'h00 & m;
`endif
  endfunction

  // Vector-level reference: which of the 8 input combinations disagree with
  // the checker's notion of the good gate.
  task automatic ref_model(input logic inv, input int mode, input logic [7:0] mask,
                           output logic [3:0] err, output logic [2:0] fail,
                           output logic [7:0] map, output logic pass);
    logic good;
    err = 4'd0; fail = 3'd0; map = 8'h00;
    for (int v = 0; v < 8; v++) begin
      good = (v != 0) ^ inv;
      if (gate_out(mode, mask, 3'(v)) != good) begin
        if (err == 4'd0) fail = 3'(v);
        err = err + 4'd1;
        map[v] = 1'b1;
      end
    end
    pass = (err == 4'd0);
  endtask

  task automatic run_sweep(input logic s, input int mode, input logic [7:0] mask,
                           input logic [3:0] e_err, input logic [2:0] e_fail,
                           input logic [7:0] e_map, input logic e_pass, input bit extra);
    int g, st, total, done_n, a_bad, ovl, busy_bad;
    logic [2:0] prev;
    logic [2:0] exp_a[$];
    sel = s;
    if (s) begin mode1 = mode; mask1 = mask; end else begin mode0 = mode; mask0 = mask; end
    g  = s ? 0 : 5;
    st = s ? 1 : 10;
    total = 8 * (g + st) + 1;
    exp_a.delete();
    prev = 3'd0;
    for (int v = 0; v < 8; v++) begin
      repeat (g)  exp_a.push_back(prev);
      repeat (st) exp_a.push_back(3'(v));
      prev = 3'(v);
    end
    done_n = 0; a_bad = 0; ovl = 0; busy_bad = 0;
    @(negedge ck);
    set_start(1'b1);
    for (int n = 1; n <= total + 20; n++) begin
      @(negedge ck);
      set_start(extra && (n == 2 || n == 50));
      if (n == 1)
        check("start_clears", {cur_err, cur_fail, cur_map, cur_done, cur_pass, cur_busy},
              {4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1});
      if (cur_busy && cur_done) ovl++;
      if (cur_done) begin
        done_n = n;
        break;
      end
      if (!cur_busy) busy_bad++;
      if (n <= total - 1 && cur_a !== exp_a[n-1]) a_bad++;
    end
    set_start(1'b0);
    check("done_latency", 32'(done_n), 32'(total));
    check("a_sequence_errs", 32'(a_bad), 32'd0);
    check("busy_done_errs", 32'(ovl + busy_bad), 32'd0);
    check("err_cnt", 32'(cur_err), 32'(e_err));
    check("fail_vec", 32'(cur_fail), 32'(e_fail));
    check("result_map", 32'(cur_map), 32'(map_visible(e_map)));
    check("pass", 32'(cur_pass), 32'(e_pass));
    check("a_zero_in_done", 32'(cur_a), 32'd0);
  endtask

  typedef struct {
    logic       s;
    int         mode;
    logic [7:0] mask;
    logic [3:0] err;
    logic [2:0] fail;
    logic [7:0] map;
    logic       pass;
    bit         extra;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r_err;
    logic [2:0] r_fail;
    logic [7:0] r_map;
    logic       r_pass;
    logic       rs;
    int         rm;
    logic [7:0] rk;

    tbl[0] = '{1'b0, 0, 8'h00, 4'd0, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 2, 8'h00, 4'd7, 3'd1, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1, 8'h00, 4'd8, 3'd0, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 3, 8'h24, 4'd2, 3'd2, 8'h24, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 0, 8'h00, 4'd0, 3'd0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1, 8'h00, 4'd0, 3'd0, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 0, 8'h00, 4'd8, 3'd0, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 3, 8'h81, 4'd6, 3'd1, 8'h7E, 1'b0, 1'b0};

    // Reset state
    rn = 1'b0;
    repeat (3) @(negedge ck);
    check("reset_def", {d0_a1, d0_a2, d0_a3, d0_busy, d0_done, d0_pass, d0_err, d0_fail, d0_map}, 32'd0);
    check("reset_fast", {d1_a1, d1_a2, d1_a3, d1_busy, d1_done, d1_pass, d1_err, d1_fail, d1_map}, 32'd0);
    #2 rn = 1'b1;
    repeat (2) @(negedge ck);

    // Table-driven sweeps (back to back, so later ones start from DONE)
    for (int i = 0; i < 8; i++)
      run_sweep(tbl[i].s, tbl[i].mode, tbl[i].mask, tbl[i].err, tbl[i].fail,
                tbl[i].map, tbl[i].pass, tbl[i].extra);

    // Reset pulse during vector 4 settle, with errors already accumulated
    sel = 1'b0; mode0 = 2; mask0 = 8'h00;
    @(negedge ck);
    start0 = 1'b1;
    for (int n = 1; n <= 68; n++) begin
      @(negedge ck);
      start0 = 1'b0;
    end
    check("pre_reset_vec4", {29'd0, d0_a1, d0_a2, d0_a3}, 32'd4);
    check("pre_reset_err", 32'(d0_err), 32'd3);
    #2 rn = 1'b0;
    #1;
    check("async_reset_def", {d0_a1, d0_a2, d0_a3, d0_busy, d0_done, d0_pass, d0_err, d0_fail, d0_map}, 32'd0);
    @(negedge ck);
    #2 rn = 1'b1;
    repeat (5) @(negedge ck);
    check("no_resume", {d0_a1, d0_a2, d0_a3, d0_busy, d0_done, d0_err}, 32'd0);
    run_sweep(1'b0, 2, 8'h00, 4'd7, 3'd1, 8'hFE, 1'b0, 1'b0);

    // Randomized sweeps against the reference model
    for (int k = 0; k < 6; k++) begin
      rs = 1'($urandom_range(0, 1));
      rm = int'($urandom_range(0, 3));
      rk = 8'($urandom);
      ref_model(rs, rm, rk, r_err, r_fail, r_map, r_pass);
      run_sweep(rs, rm, rk, r_err, r_fail, r_map, r_pass, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/or3_response_checker.md
OR3_RESPONSE_CHECKER -- requirements
Module: or3_response_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 10, meaning cycles a vector is held before ZN is sampled (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 5, meaning idle cycles before each vector is applied (legal range 0..255).
REQ-003 The block SHALL have parameter INVERT, default 0, meaning 0 checks OR3 (ZN=A1|A2|A3) and 1 checks NOR3 (ZN=~(A1|A2|A3)).
REQ-004 The block SHALL have port CK, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port RN, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port START, input, 1, a single-cycle request to begin a sweep.
REQ-007 The block SHALL have port ZN, input, 1, the gate-under-test output being checked.
REQ-008 The block SHALL have ports A1, A2, A3, output, 1 each, the registered stimulus driving the gate under test.
REQ-009 The block SHALL have port BUSY, output, 1, high while a sweep is in progress.
REQ-010 The block SHALL have port DONE, output, 1, high from sweep completion until the next accepted START or reset.
REQ-011 The block SHALL have port PASS, output, 1, valid while DONE is high, meaning zero mismatches.
REQ-012 The block SHALL have port ERR_CNT, output, 4, the number of mismatching vectors (0..8).
REQ-013 The block SHALL have port FAIL_VEC, output, 3, the first failing vector as {A1,A2,A3}, 0 if none.
REQ-014 The block SHALL have port RESULT_MAP, output, 8, where bit n is 1 if vector n mismatched.

Function
REQ-015 The FSM SHALL have states IDLE, GAP, SETTLE, DONE; IDLE is entered on reset.
REQ-016 START in IDLE or DONE SHALL clear ERR_CNT, FAIL_VEC, and RESULT_MAP, set the vector index to 0, and enter GAP (or SETTLE directly if GAP_CYCLES=0).
REQ-017 START while BUSY SHALL be ignored.
REQ-018 In GAP, A1..A3 SHALL hold their previous values for exactly GAP_CYCLES cycles.
REQ-019 On SETTLE entry, {A1,A2,A3} SHALL equal the vector index and be held for exactly SETTLE_CYCLES cycles.
REQ-020 On the last SETTLE cycle, ZN SHALL be compared to the expected value; on mismatch ERR_CNT SHALL increment and the result bit SHALL be set; FAIL_VEC SHALL capture only the first mismatch.
REQ-021 After vector 7 is sampled, the FSM SHALL enter DONE; otherwise it SHALL increment the index and return to GAP; the index SHALL never wrap mid-sweep.
REQ-022 Sweep length from accepted START to DONE high SHALL be exactly 8*(GAP_CYCLES+SETTLE_CYCLES)+1 cycles.
REQ-023 BUSY SHALL be high in GAP and SETTLE only, and BUSY and DONE SHALL never both be high.
REQ-024 In DONE, A1..A3 SHALL return to 0, and PASS SHALL equal (ERR_CNT==0).
REQ-025 ERR_CNT SHALL saturate at 8, which is reachable only by all-vector failure.

Reset
REQ-026 RN low SHALL asynchronously force IDLE, A1..A3=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, and RESULT_MAP=0, including mid-sweep.
REQ-027 After RN deasserts, the block SHALL wait for a new START; an aborted sweep SHALL NOT resume.

Configuration
REQ-028 With OR3_CHK_RESULT_MAP_EN defined, RESULT_MAP SHALL be updated per REQ-020.
REQ-029 Without OR3_CHK_RESULT_MAP_EN, RESULT_MAP SHALL be constant 0 and its storage SHALL be omitted; all other behaviour SHALL be unchanged.

Verification
REQ-030 Default params, ideal OR3 model, START pulse -> DONE at cycle 121, PASS=1, ERR_CNT=0, FAIL_VEC=0, and A sequence 000..111 each held 10 cycles.
REQ-031 Model with ZN stuck at 0 -> ERR_CNT=7, FAIL_VEC=3'b001, RESULT_MAP=8'hFE (macro on) or 8'h00 (macro off), PASS=0.
REQ-032 INVERT=1 with ideal NOR3 model -> PASS=1, and the same model with INVERT=0 -> ERR_CNT=8, RESULT_MAP=8'hFF.
REQ-033 RN pulsed low during vector 4 SETTLE -> all outputs 0 immediately, then a START gives a full fresh 8-vector sweep with correct results.
REQ-034 START reasserted at cycles 2 and 50 of a sweep -> both ignored and completion timing unchanged, and START in DONE -> counters cleared and a new sweep begins.
REQ-035 GAP_CYCLES=0 and SETTLE_CYCLES=1 -> DONE after 9 cycles, and vectors change every cycle.
